mem_to_reg_loader: RTL and testbench

Block-load sequencer that moves a run of words from the 16x4 data RAM into the 4-bit register file (registers 1..9). It is the read-back direction of the existing register-to-memory store path: it drives the RAM read port (rd, addr) and the register-file write port (Wt_addr, Wt_data, L_S). It accepts one command at a time and reports completion with a done pulse.

---
 rtl/mem_to_reg_loader_pkg.sv | 22 ++
 rtl/mem_to_reg_loader_if.sv | 41 ++++
 rtl/mem_to_reg_loader.sv | 102 ++++++++++
 tb/tb_mem_to_reg_loader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_to_reg_loader_pkg.sv
// Shared widths and state encoding for the memory-to-register block loader.
// Imported by the loader, its interface and the bench.
package mem_to_reg_loader_pkg;

  localparam int P_AW       = 4;
  localparam int P_DW       = 4;
  localparam int P_RA_W     = 4;
  localparam int P_REG_LAST = 9;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RD   = ST_RD,
    WB   = ST_WB,
    FIN  = ST_FIN
  } state_e;

endpackage

// File: rtl/mem_to_reg_loader_if.sv
// Command, RAM read port and register-file write port of the loader.
// slave = loader side, master = the side issuing commands and owning the RAM.
interface mem_to_reg_loader_if
  import mem_to_reg_loader_pkg::*;
#(
  parameter int AW   = P_AW,
  parameter int DW   = P_DW,
  parameter int RA_W = P_RA_W
);

  logic            start;
  logic [AW-1:0]   mem_base;
  logic [RA_W-1:0] reg_dst;
  logic [AW-1:0]   count;
  logic            busy;
  logic            done;
  logic            err;
  logic            mem_rd;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data;
  logic            reg_we;
  logic [RA_W-1:0] reg_waddr;
  logic [DW-1:0]   reg_wdata;

  modport slave (
    input  start, mem_base, reg_dst, count,
    input  mem_data,
    output busy, done, err,
    output mem_rd, mem_addr,
    output reg_we, reg_waddr, reg_wdata
  );

  modport master (
    output start, mem_base, reg_dst, count,
    output mem_data,
    input  busy, done, err,
    input  mem_rd, mem_addr,
    input  reg_we, reg_waddr, reg_wdata
  );

endinterface

// File: rtl/mem_to_reg_loader.sv
// Block-load sequencer: reads a run of RAM words and writes them to
// consecutive registers, two cycles per word, with a done/err pulse.
module mem_to_reg_loader
  import mem_to_reg_loader_pkg::*;
#(
  parameter int AW       = P_AW,
  parameter int DW       = P_DW,
  parameter int RA_W     = P_RA_W,
  parameter int REG_LAST = P_REG_LAST
)(
  input logic clk,
  input logic rst,
  mem_to_reg_loader_if.slave bus
);

  state_e          state;
  state_e          state_n;
  logic [AW-1:0]   cur_addr;
  logic [AW-1:0]   remain;
  logic [AW-1:0]   addr_q;
  logic [RA_W-1:0] cur_reg;
  logic [RA_W-1:0] waddr_q;
  logic            err_q;
  logic            rej;

  // Last destination is checked one bit wider so a run past the top
  // of the register space cannot wrap back into range.
  function automatic logic reject(
    input logic [RA_W-1:0] dst,
    input logic [AW-1:0]   cnt
  );
    logic [RA_W:0] last;
    last = {1'b0, dst} + (RA_W+1)'(cnt) - (RA_W+1)'(1);
    return (cnt != '0) &&
           ((dst == '0) || (last > (RA_W+1)'(REG_LAST)));
  endfunction

  assign rej = reject(bus.reg_dst, bus.count);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if ((bus.count == '0) || rej) state_n = FIN;
          else                          state_n = RD;
        end
      end
      RD:  state_n = WB;
      WB:  state_n = (remain == AW'(1)) ? FIN : RD;
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cur_addr <= '0;
      cur_reg  <= '0;
      remain   <= '0;
      addr_q   <= '0;
      waddr_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            cur_addr <= bus.mem_base;
            cur_reg  <= bus.reg_dst;
            remain   <= bus.count;
            err_q    <= rej;
          end
        end
        RD: waddr_q <= cur_reg;
        WB: begin
          cur_addr <= cur_addr + AW'(1);
          cur_reg  <= cur_reg + RA_W'(1);
          remain   <= remain - AW'(1);
        end
        FIN: err_q <= 1'b0;
        default: ;
      endcase
      // mem_addr only moves when a read is about to be strobed
      if (state_n == RD) begin
        if (state == IDLE) addr_q <= bus.mem_base;
        else               addr_q <= cur_addr + AW'(1);
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == FIN);
  assign bus.err       = (state == FIN) && err_q;
  assign bus.mem_rd    = (state == RD);
  assign bus.mem_addr  = addr_q;
  assign bus.reg_we    = (state == WB);
  assign bus.reg_waddr = waddr_q;
  assign bus.reg_wdata = (state == WB) ? bus.mem_data : '0;

endmodule

// File: tb/tb_mem_to_reg_loader.sv
// Bench for mem_to_reg_loader: RAM and register-file models, a cycle
// schedule model built per command, and directed plus random commands.
module tb_mem_to_reg_loader;
  import mem_to_reg_loader_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_regs = 1'b1;
  always #5 clk = ~clk;

  mem_to_reg_loader_if #(.AW(4), .DW(4), .RA_W(4)) bus();

  mem_to_reg_loader #(
    .AW(4), .DW(4), .RA_W(4), .REG_LAST(9)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [3:0] ram [16];
  logic [3:0] regs [16];
  logic [3:0] shadow [16];

  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_data <= ram[bus.mem_addr];
    if (clr_regs) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (bus.reg_we && bus.reg_waddr != 4'd0) begin
      regs[bus.reg_waddr] <= bus.reg_wdata;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic       rd;
    logic [3:0] addr;
    logic       we;
    logic [3:0] waddr;
    logic [3:0] wdata;
  } exp_t;

  exp_t exp_q [int];
  int   free_cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_we_obs = 0;
  int   n_done_obs = 0;
  int   last_done_cyc = -1;
  logic [3:0] addr_log [$];

  task automatic chk(input string nm, input int act, input int want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, want, cyc);
    end
  endtask

  // Expected per-cycle outputs derived from the command alone
  task automatic model_cmd(input int m, input int base,
                           input int dst, input int cnt);
    exp_t e;
    bit   rej;
    rej = (cnt != 0) && ((dst == 0) || (dst + cnt - 1 > 9));
    if (cnt == 0 || rej) begin
      e = '0;
      e.busy = 1'b1;
      e.done = 1'b1;
      e.err  = rej;
      exp_q[m+1] = e;
      free_cyc = m + 2;
    end else begin
      for (int k = 0; k < cnt; k++) begin
        e = '0;
        e.busy = 1'b1;
        e.rd   = 1'b1;
        e.addr = 4'((base + k) % 16);
        exp_q[m+2*k+1] = e;
        e = '0;
        e.busy  = 1'b1;
        e.we    = 1'b1;
        e.waddr = 4'(dst + k);
        e.wdata = ram[(base + k) % 16];
        exp_q[m+2*k+2] = e;
      end
      e = '0;
      e.busy = 1'b1;
      e.done = 1'b1;
      exp_q[m+2*cnt+1] = e;
      free_cyc = m + 2*cnt + 2;
    end
  endtask

  // Caller must be at a falling edge
  task automatic issue(input int base, input int dst,
                       input int cnt, output int m);
    bus.mem_base = 4'(base);
    bus.reg_dst  = 4'(dst);
    bus.count    = 4'(cnt);
    bus.start    = 1'b1;
    m = cyc;
    if (m >= free_cyc) model_cmd(m, base, dst, cnt);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    while (cyc < free_cyc) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  int'(bus.busy),      0);
    chk({tag, "_done"},  int'(bus.done),      0);
    chk({tag, "_err"},   int'(bus.err),       0);
    chk({tag, "_rd"},    int'(bus.mem_rd),    0);
    chk({tag, "_addr"},  int'(bus.mem_addr),  0);
    chk({tag, "_we"},    int'(bus.reg_we),    0);
    chk({tag, "_waddr"}, int'(bus.reg_waddr), 0);
    chk({tag, "_wdata"}, int'(bus.reg_wdata), 0);
  endtask

  initial begin : compare
    exp_t e;
    forever begin
      @(negedge clk);
      if (clr_regs) begin
        for (int i = 0; i < 16; i++) shadow[i] = '0;
      end
      if (!rst) begin
        e = exp_q.exists(cyc) ? exp_q[cyc] : '0;
        chk("busy",   int'(bus.busy),   int'(e.busy));
        chk("done",   int'(bus.done),   int'(e.done));
        chk("err",    int'(bus.err),    int'(e.err));
        chk("mem_rd", int'(bus.mem_rd), int'(e.rd));
        chk("reg_we", int'(bus.reg_we), int'(e.we));
        if (e.rd) chk("mem_addr", int'(bus.mem_addr), int'(e.addr));
        if (e.we) begin
          chk("reg_waddr", int'(bus.reg_waddr), int'(e.waddr));
          chk("reg_wdata", int'(bus.reg_wdata), int'(e.wdata));
          if (e.waddr != 4'd0) shadow[e.waddr] = e.wdata;
        end
        if (bus.reg_we) n_we_obs++;
        if (bus.done) begin
          n_done_obs++;
          last_done_cyc = cyc;
        end
        if (bus.mem_rd) addr_log.push_back(bus.mem_addr);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int m, m2, we0, dn0, sz;
    bus.start    = 1'b0;
    bus.mem_base = '0;
    bus.reg_dst  = '0;
    bus.count    = '0;
    for (int i = 0; i < 16; i++) ram[i] = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    clr_regs = 1'b0;
    free_cyc = cyc;
    @(negedge clk);

    // Basic three-word load
    ram[3] = 4'd7; ram[4] = 4'd4; ram[5] = 4'd9;
    we0 = n_we_obs;
    issue(3, 2, 3, m);
    wait_idle();
    chk("plan_done_cycle", last_done_cyc - m, 7);
    chk("plan_writes", n_we_obs - we0, 3);
    chk("plan_r2", int'(regs[2]), 7);
    chk("plan_r3", int'(regs[3]), 4);
    chk("plan_r4", int'(regs[4]), 9);

    // Address wrap
    ram[15] = 4'd1; ram[0] = 4'd2;
    sz = addr_log.size();
    issue(15, 8, 2, m);
    wait_idle();
    chk("wrap_addr0", int'(addr_log[sz]), 15);
    chk("wrap_addr1", int'(addr_log[sz+1]), 0);
    chk("wrap_r8", int'(regs[8]), 1);
    chk("wrap_r9", int'(regs[9]), 2);

    // Rejects and empty command
    we0 = n_we_obs;
    sz = addr_log.size();
    issue(0, 8, 3, m);
    wait_idle();
    chk("rej_hi_done_cycle", last_done_cyc - m, 1);
    issue(0, 0, 1, m);
    wait_idle();
    chk("rej_r0_done_cycle", last_done_cyc - m, 1);
    issue(5, 3, 0, m);
    wait_idle();
    chk("cnt0_done_cycle", last_done_cyc - m, 1);
    chk("rej_no_writes", n_we_obs - we0, 0);
    chk("rej_no_reads", addr_log.size() - sz, 0);
    chk("rej_r8_kept", int'(regs[8]), 1);

    // Second start during a transfer is dropped
    we0 = n_we_obs;
    dn0 = n_done_obs;
    issue(3, 2, 3, m);
    @(negedge clk);
    issue(9, 1, 2, m2);
    wait_idle();
    chk("spur_writes", n_we_obs - we0, 3);
    chk("spur_dones", n_done_obs - dn0, 1);

    // Reset during write-back of word 1
    ram[4] = 4'd11; ram[5] = 4'd12; ram[6] = 4'd13; ram[7] = 4'd14;
    we0 = n_we_obs;
    dn0 = n_done_obs;
    issue(4, 1, 4, m);
    while (cyc < m + 3) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int c = cyc; c < cyc + 16; c++) exp_q.delete(c);
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    free_cyc = cyc;
    chk("midrst_writes", n_we_obs - we0, 1);
    chk("midrst_dones", n_done_obs - dn0, 0);
    chk("midrst_r1", int'(regs[1]), 11);
    chk("midrst_r2", int'(regs[2]), int'(shadow[2]));
    issue(4, 1, 4, m);
    wait_idle();
    chk("after_rst_r4", int'(regs[4]), 14);

    // Random commands, back-to-back or with gaps
    for (int t = 0; t < 80; t++) begin
      for (int i = 0; i < 16; i++) ram[i] = 4'($urandom_range(0, 15));
      issue($urandom_range(0, 15), $urandom_range(0, 10),
            $urandom_range(0, 5), m);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        issue($urandom_range(0, 15), $urandom_range(1, 9), 1, m2);
      end
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    for (int i = 0; i < 16; i++)
      chk($sformatf("regfile_r%0d", i), int'(regs[i]), int'(shadow[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
